// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit serializer.
package uart_pkg;

    localparam int   UART_DIV_WIDTH  = 32;
    localparam logic UART_STOP_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake, baud divisor and line outputs between the APB-side
// TX holding logic (master) and the serializer (slave).
interface uart_tx_serializer_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = UART_DIV_WIDTH
);

    logic [DIV_WIDTH-1:0] baud_div;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output baud_div,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  baud_div,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_serial,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/baud_tick_counter.sv
// Bit-time counter: counts 0..div-1 and flags the last cycle of each bit.
// div is always at least 1, so div-1 never underflows and the count never
// reaches the top of the counter range.
module baud_tick_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = !clear && (cnt == (div - WIDTH'(1)));

    // Advance the bit-time count, reloading zero at each bit boundary or while held clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmit serializer: accepts one byte in IDLE, latches the baud
// divisor with it, then sends start, data LSB first, and one stop bit.
// The line output is registered from the next-state values so the first
// start-bit cycle follows the accept edge directly.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus
);

    localparam int             BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t         state;
    uart_tx_state_t         state_next;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_next;
    logic [BIT_W-1:0]       bit_q;
    logic [BIT_W-1:0]       bit_next;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_next;
    logic                   serial_q;
    logic                   serial_next;
    logic                   tick;

    baud_tick_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    assign bus.tx_ready  = (state == IDLE);
    assign bus.tx_busy   = (state != IDLE);
    assign bus.tx_done   = (state == STOP) && tick;
    assign bus.tx_serial = serial_q;

    // Register the frame state, shift data, bit index, latched divisor and line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            div_q    <= DIV_WIDTH'(1);
            serial_q <= UART_STOP_LEVEL;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_q    <= bit_next;
            div_q    <= div_next;
            serial_q <= serial_next;
        end
    end

    // Sequence the frame on bit ticks and derive the next line level from the next state.
    always_comb begin
        state_next  = state;
        shift_next  = shift_q;
        bit_next    = bit_q;
        div_next    = div_q;
        serial_next = UART_STOP_LEVEL;

        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_next = START;
                    shift_next = bus.tx_data;
                    bit_next   = '0;
                    div_next   = (bus.baud_div == '0) ? DIV_WIDTH'(1) : bus.baud_div;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            default: serial_next = UART_STOP_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: the driver pushes each expected frame (byte, bit time,
// sample index of its start bit) to a scoreboard; a negedge monitor pops it
// when the start is due and checks the line, done, busy and ready each cycle.
module tb_uart_tx_serializer;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         start_idx;
    } frame_t;

    logic clk;
    logic rst;

    uart_tx_serializer_if #(.DATA_BITS(8), .DIV_WIDTH(32)) bus ();

    uart_tx_serializer #(
        .DATA_BITS (8),
        .DIV_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    frame_t sb[$];
    frame_t cur;
    int     checks     = 0;
    int     failures   = 0;
    int     idx        = 0;
    int     rel        = 0;
    int     abort_idx  = -1;
    int     last_start = 0;
    bit     active     = 0;
    bit     mon_en     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at sample %0d: observed=%0h expected=%0h", tag, idx, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [31:0] div);
        frame_t f;
        @(posedge clk);
        #1;
        bus.tx_data  = data;
        bus.baud_div = div;
        bus.tx_valid = 1'b1;
        f.data       = data;
        f.div        = (div == 0) ? 1 : int'(div);
        f.start_idx  = idx + 2;
        last_start   = f.start_idx;
        sb.push_back(f);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((sb.size() != 0 || active) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checkOutput("idle_wait_pending", sb.size() + int'(active), 0);
        waitCycles(2);
    endtask

    // Monitor: one sample per negedge, framed against the scoreboard.
    initial begin
        logic exp_bit;
        int   b;
        int   total;
        forever begin
            @(negedge clk);
            idx++;
            if (mon_en) begin
                if (active && idx == abort_idx) begin
                    active = 0;
                end
                if (sb.size() > 0 && sb[0].start_idx == idx) begin
                    checkOutput("frame_overlap", 32'(active), 0);
                    cur    = sb.pop_front();
                    active = 1;
                    rel    = 0;
                end
                if (active) begin
                    total = 10 * cur.div;
                    b     = rel / cur.div;
                    if (b == 0)      exp_bit = 1'b0;
                    else if (b <= 8) exp_bit = cur.data[b-1];
                    else             exp_bit = 1'b1;
                    checkOutput("frame_serial", 32'(bus.tx_serial), 32'(exp_bit));
                    checkOutput("frame_done",   32'(bus.tx_done),   32'(rel == total - 1));
                    checkOutput("frame_busy",   32'(bus.tx_busy),   1);
                    checkOutput("frame_ready",  32'(bus.tx_ready),  0);
                    rel++;
                    if (rel == total) active = 0;
                end else begin
                    checkOutput("idle_serial", 32'(bus.tx_serial), 1);
                    checkOutput("idle_done",   32'(bus.tx_done),   0);
                    checkOutput("idle_busy",   32'(bus.tx_busy),   0);
                    checkOutput("idle_ready",  32'(bus.tx_ready),  1);
                end
            end
        end
    end

    initial begin
        frame_t f;
        int     s;
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.baud_div = 32'd1;
        waitCycles(3);
        checkOutput("reset_serial", 32'(bus.tx_serial), 1);
        checkOutput("reset_ready",  32'(bus.tx_ready),  1);
        checkOutput("reset_busy",   32'(bus.tx_busy),   0);
        checkOutput("reset_done",   32'(bus.tx_done),   0);
        rst    = 1'b0;
        mon_en = 1;
        waitCycles(2);

        $display("[TB] D=4 frame of 8'hA5");
        applyStimulus(8'hA5, 32'd4);
        waitIdle();

        $display("[TB] baud_div=0 behaves as D=1");
        applyStimulus(8'h00, 32'd0);
        waitIdle();

        $display("[TB] tx_valid held high, back-to-back frames");
        @(posedge clk);
        #1;
        bus.tx_data  = 8'h01;
        bus.baud_div = 32'd2;
        bus.tx_valid = 1'b1;
        f.data = 8'h01; f.div = 2; f.start_idx = idx + 2;
        sb.push_back(f);
        s = f.start_idx + 10 * 2 + 1;
        f.data = 8'h80; f.div = 2; f.start_idx = s;
        sb.push_back(f);
        waitCycles(1);
        bus.tx_data = 8'h80;
        while (idx < s - 1) begin
            @(posedge clk);
            #1;
        end
        bus.tx_valid = 1'b0;
        waitIdle();

        $display("[TB] baud_div change mid-frame");
        applyStimulus(8'h3C, 32'd4);
        waitCycles(8);
        bus.baud_div = 32'd8;
        waitIdle();
        applyStimulus(8'hC3, 32'd8);
        waitIdle();

        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0, 32'd4);
        s = last_start;
        abort_idx = s + 15;
        while (idx < s + 13) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        waitIdle();
        waitCycles(10);

        $display("[TB] tx_valid pulse while busy is ignored");
        applyStimulus(8'h5A, 32'd2);
        waitCycles(5);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        waitCycles(1);
        bus.tx_valid = 1'b0;
        waitIdle();
        waitCycles(30);

        $display("[TB] short random frames");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom), 32'($urandom_range(0, 3)));
            waitIdle();
        end

        waitCycles(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
